// File: rtl/alu_w.sv
// alu_w: multi-cycle integer ALU with a three-state IDLE/CALC/DONE control FSM.
// Add/sub/logic ops take one CALC cycle; MUL is shift-add and DIV/RMD are
// restoring division, both iterating one bit per cycle over WIDTH cycles.
// Signed MUL/DIV/RMD run on operand magnitudes and fix the sign at the end.
module alu_w #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       dtype,
   input  logic [4:0]       operator,
   output logic             busy,
   output logic [WIDTH-1:0] calc_res,
   output logic             alu_done,
   output logic             ovf,
   output logic             err
);

   localparam logic [4:0] OpSum = 5'h10;
   localparam logic [4:0] OpSub = 5'h08;
   localparam logic [4:0] OpMul = 5'h04;
   localparam logic [4:0] OpDiv = 5'h02;
   localparam logic [4:0] OpRmd = 5'h01;
   localparam logic [4:0] OpAnd = 5'h11;
   localparam logic [4:0] OpOr  = 5'h12;
   localparam logic [4:0] OpXor = 5'h14;

   localparam logic [WIDTH-1:0]   MinVal  = {1'b1, {(WIDTH-1){1'b0}}};
   // Magnitude of the most negative signed value, widened to product width.
   localparam logic [2*WIDTH-1:0] ProdMin = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sgn_q, sgn_d;
   logic [4:0]       op_q, op_d;
   // hi: partial product high half / partial remainder; lo: multiplier / quotient.
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             ovf_q, ovf_d, err_q, err_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
   logic             div_ge, is_mul, is_iter;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [WIDTH-1:0] fin_res;
   logic             fin_ovf, fin_err;

   // Only the signed bit of the type mask matters.
   logic unused_dtype;
   assign unused_dtype = ^dtype[3:1];

   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x, input logic s);
      return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
   endfunction

   assign mag_a   = mag_f(a_q, sgn_q);
   assign mag_b   = mag_f(b_q, sgn_q);
   assign is_mul  = (op_q == OpMul);
   assign is_iter = is_mul || (((op_q == OpDiv) || (op_q == OpRmd)) && (b_q != '0));

   // One shift-add or restoring-division step from the current hi/lo state.
   always_comb begin
      mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mag_a : {WIDTH{1'b0}})};
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, mag_b};
      div_ge  = (rem_sh >= {1'b0, mag_b});
      if (is_mul) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
         step_hi = div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], div_ge};
      end
   end

   logic [WIDTH:0]     add_w, sub_w;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic               prod_neg, q_neg, r_neg;

   // Final result, overflow and error flags; valid on the last CALC cycle.
   always_comb begin
      fin_res  = '0;
      fin_ovf  = 1'b0;
      fin_err  = 1'b0;
      add_w    = {1'b0, a_q} + {1'b0, b_q};
      sub_w    = {1'b0, a_q} - {1'b0, b_q};
      prod     = {step_hi, step_lo};
      prod_neg = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      prod_s   = prod_neg ? (~prod + 1'b1) : prod;
      q_neg    = prod_neg;
      r_neg    = sgn_q & a_q[WIDTH-1];
      case (op_q)
         OpSum: begin
            fin_res = add_w[WIDTH-1:0];
            fin_ovf = sgn_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]))
                            : add_w[WIDTH];
         end
         OpSub: begin
            fin_res = sub_w[WIDTH-1:0];
            fin_ovf = sgn_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]))
                            : sub_w[WIDTH];
         end
         OpMul: begin
            fin_res = prod_s[WIDTH-1:0];
            if (sgn_q) fin_ovf = prod_neg ? (prod > ProdMin) : (prod >= ProdMin);
            else       fin_ovf = |prod[2*WIDTH-1:WIDTH];
         end
         OpDiv: begin
            if (b_q == '0) begin
               fin_res = '1;
               fin_err = 1'b1;
            end else begin
               fin_res = q_neg ? (~step_lo + 1'b1) : step_lo;
               fin_ovf = sgn_q && (a_q == MinVal) && (b_q == '1);
            end
         end
         OpRmd: begin
            if (b_q == '0) begin
               fin_res = a_q;
               fin_err = 1'b1;
            end else begin
               fin_res = r_neg ? (~step_hi + 1'b1) : step_hi;
            end
         end
         OpAnd:   fin_res = a_q & b_q;
         OpOr:    fin_res = a_q | b_q;
         OpXor:   fin_res = a_q ^ b_q;
         default: fin_err = 1'b1;
      endcase
   end

   // Control FSM: capture on accept, iterate in CALC, load results entering DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCalc;
               cnt_d   = '0;
               a_d     = src1;
               b_d     = src2;
               sgn_d   = dtype[0];
               op_d    = operator;
               hi_d    = '0;
               lo_d    = (operator == OpMul) ? mag_f(src2, dtype[0]) : mag_f(src1, dtype[0]);
            end
         end
         StCalc: begin
            if (is_iter) begin
               hi_d  = step_hi;
               lo_d  = step_lo;
               cnt_d = cnt_q + 1'b1;
            end
            if (!is_iter || (cnt_q == CNT_W'(WIDTH - 1))) begin
               state_d = StDone;
               res_d   = fin_res;
               ovf_d   = fin_ovf;
               err_d   = fin_err;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign alu_done = (state_q == StDone);
   assign calc_res = res_q;
   assign ovf      = ovf_q;
   assign err      = err_q;

endmodule

// File: tb/tb_alu_w.sv
// Directed testbench for alu_w at WIDTH=8 with hand-computed expectations.
module tb_alu_w;

   localparam logic [4:0] OpSum = 5'h10;
   localparam logic [4:0] OpSub = 5'h08;
   localparam logic [4:0] OpMul = 5'h04;
   localparam logic [4:0] OpDiv = 5'h02;
   localparam logic [4:0] OpRmd = 5'h01;
   localparam logic [4:0] OpAnd = 5'h11;
   localparam logic [4:0] OpOr  = 5'h12;
   localparam logic [4:0] OpXor = 5'h14;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       start;
   logic [7:0] src1, src2;
   logic [3:0] dtype;
   logic [4:0] operator;
   logic       busy, alu_done, ovf, err;
   logic [7:0] calc_res;

   int n_tests = 0;
   int n_fail  = 0;

   alu_w #(.WIDTH(8)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (start),
      .src1     (src1),
      .src2     (src2),
      .dtype    (dtype),
      .operator (operator),
      .busy     (busy),
      .calc_res (calc_res),
      .alu_done (alu_done),
      .ovf      (ovf),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op, scramble the inputs after acceptance, and check latency and results.
   task automatic do_op(input string tag, input logic [4:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic s, input logic [7:0] er,
                        input logic eo, input logic ee, input int el);
      int lat;
      bit seen;
      @(negedge clk);
      src1     = a;
      src2     = b;
      dtype    = s ? 4'b1001 : 4'b1000;
      operator = op;
      start    = 1'b1;
      lat      = 0;
      seen     = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            start    = 1'b0;
            src1     = ~a;
            src2     = 8'h00;
            operator = 5'h1f;
            dtype    = ~dtype;
         end
         if (alu_done) seen = 1'b1;
      end
      check({tag, "_lat"}, 32'(lat), 32'(el));
      check({tag, "_res"}, 32'(calc_res), 32'(er));
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
      check({tag, "_err"}, 32'(err), 32'(ee));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 32'(alu_done), 32'd0);
      check({tag, "_hold"}, 32'(calc_res), 32'(er));
   endtask

   int lat;
   int cnt;

   initial begin
      n_rst    = 1'b0;
      start    = 1'b0;
      src1     = '0;
      src2     = '0;
      dtype    = '0;
      operator = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(alu_done), 32'd0);
      check("rst_res", 32'(calc_res), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      do_op("sum_u",    OpSum, 8'd200, 8'd100, 1'b0, 8'h2c, 1'b1, 1'b0, 2);
      do_op("sum_s",    OpSum, 8'd100, 8'd50,  1'b1, 8'h96, 1'b1, 1'b0, 2);
      do_op("sub_u",    OpSub, 8'd5,   8'd10,  1'b0, 8'hfb, 1'b1, 1'b0, 2);
      do_op("sub_s",    OpSub, 8'd5,   8'd10,  1'b1, 8'hfb, 1'b0, 1'b0, 2);
      do_op("mul_s",    OpMul, 8'hfd,  8'd7,   1'b1, 8'heb, 1'b0, 1'b0, 9);
      do_op("mul_sovf", OpMul, 8'd16,  8'd16,  1'b1, 8'h00, 1'b1, 1'b0, 9);
      do_op("mul_u",    OpMul, 8'd15,  8'd17,  1'b0, 8'hff, 1'b0, 1'b0, 9);
      do_op("mul_uovf", OpMul, 8'd16,  8'd16,  1'b0, 8'h00, 1'b1, 1'b0, 9);
      do_op("mul_smin", OpMul, 8'hf0,  8'd8,   1'b1, 8'h80, 1'b0, 1'b0, 9);
      do_op("div_s",    OpDiv, 8'hf9,  8'd2,   1'b1, 8'hfd, 1'b0, 1'b0, 9);
      do_op("rmd_s",    OpRmd, 8'hf9,  8'd2,   1'b1, 8'hff, 1'b0, 1'b0, 9);
      do_op("div_s2",   OpDiv, 8'd7,   8'hfe,  1'b1, 8'hfd, 1'b0, 1'b0, 9);
      do_op("rmd_s2",   OpRmd, 8'd7,   8'hfe,  1'b1, 8'h01, 1'b0, 1'b0, 9);
      do_op("div_u",    OpDiv, 8'd200, 8'd7,   1'b0, 8'd28,  1'b0, 1'b0, 9);
      do_op("rmd_u",    OpRmd, 8'd200, 8'd7,   1'b0, 8'd4,   1'b0, 1'b0, 9);
      do_op("div_z",    OpDiv, 8'd200, 8'd0,   1'b0, 8'hff, 1'b0, 1'b1, 2);
      do_op("rmd_z",    OpRmd, 8'd200, 8'd0,   1'b0, 8'hc8, 1'b0, 1'b1, 2);
      do_op("div_min",  OpDiv, 8'h80,  8'hff,  1'b1, 8'h80, 1'b1, 1'b0, 9);
      do_op("rmd_min",  OpRmd, 8'h80,  8'hff,  1'b1, 8'h00, 1'b0, 1'b0, 9);
      do_op("and",      OpAnd, 8'ha5,  8'h3c,  1'b0, 8'h24, 1'b0, 1'b0, 2);
      do_op("or",       OpOr,  8'ha5,  8'h3c,  1'b1, 8'hbd, 1'b0, 1'b0, 2);
      do_op("xor",      OpXor, 8'ha5,  8'h3c,  1'b0, 8'h99, 1'b0, 1'b0, 2);
      do_op("illegal",  5'h03, 8'ha5,  8'h3c,  1'b0, 8'h00, 1'b0, 1'b1, 2);

      // Second start mid-MUL must be ignored and not queued.
      @(negedge clk);
      src1 = 8'd3; src2 = 8'd5; dtype = 4'b1000; operator = OpMul; start = 1'b1;
      lat = 0;
      while (!alu_done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) start = 1'b0;
         if (lat == 3) begin
            start = 1'b1; operator = OpAnd; src1 = 8'hff; src2 = 8'h0f;
         end
         if (lat == 4) start = 1'b0;
      end
      check("midmul_lat", 32'(lat), 32'd9);
      check("midmul_res", 32'(calc_res), 32'h0f);
      cnt = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (busy || alu_done) cnt++;
      end
      check("midmul_noqueue", 32'(cnt), 32'd0);

      // Start held during the alu_done cycle must be ignored.
      @(negedge clk);
      src1 = 8'd1; src2 = 8'd2; dtype = 4'b1000; operator = OpSum; start = 1'b1;
      lat = 0;
      while (!alu_done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) start = 1'b0;
      end
      check("donest_lat", 32'(lat), 32'd2);
      start = 1'b1; operator = OpOr; src1 = 8'hf0; src2 = 8'h0f;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("donest_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("donest_done", 32'(alu_done), 32'd0);
      check("donest_res", 32'(calc_res), 32'h03);

      // Reset mid-DIV: outputs clear at once and no completion follows.
      do_op("pre_rst", OpDiv, 8'd200, 8'd0, 1'b0, 8'hff, 1'b0, 1'b1, 2);
      @(negedge clk);
      src1 = 8'd200; src2 = 8'd7; dtype = 4'b1000; operator = OpDiv; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_busy", 32'(busy), 32'd1);
      n_rst = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(alu_done), 32'd0);
      check("arst_res", 32'(calc_res), 32'd0);
      check("arst_ovf", 32'(ovf), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      cnt = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (alu_done || busy) cnt++;
      end
      check("arst_nodone", 32'(cnt), 32'd0);
      do_op("post_rst", OpSum, 8'd1, 8'd1, 1'b0, 8'h02, 1'b0, 1'b0, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_w.md
ALU_W -- requirements
Module: alu_w

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand/result width (legal range 4..32).
REQ-002 Parameter: CNT_W, default $clog2(WIDTH)+1, SHALL set the iteration counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 n_rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request an operation; it is sampled only when busy=0.
REQ-006 src1  input  WIDTH  SHALL be operand A (dividend, minuend).
REQ-007 src2  input  WIDTH  SHALL be operand B (divisor, subtrahend).
REQ-008 dtype  input  4  SHALL be the type mask, with I=8, F=4, U=2, S=1; only bit S (signed) affects behaviour.
REQ-009 operator  input  5  SHALL be the opcode: SUM=10h, SUB=08h, MUL=04h, DIV=02h, RMD=01h, AND=11h, OR=12h, XOR=14h.
REQ-010 busy  output  1  SHALL be high from the cycle after start is accepted until the cycle alu_done is high, inclusive.
REQ-011 calc_res  output  WIDTH  SHALL be the registered result.
REQ-012 alu_done  output  1  SHALL be a one-cycle completion pulse.
REQ-013 ovf  output  1  SHALL flag arithmetic overflow; it is valid with alu_done.
REQ-014 err  output  1  SHALL flag a divide by zero or an illegal opcode; it is valid with alu_done.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; IDLE->CALC on start in IDLE; CALC->DONE when the operation completes; DONE->IDLE unconditionally.
REQ-016 On start acceptance, src1, src2, dtype and operator SHALL be captured; input changes afterwards SHALL NOT affect the operation.
REQ-017 start while busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-018 AND/OR/XOR/SUM/SUB, divide-by-zero and illegal opcodes SHALL spend exactly 1 cycle in CALC: alu_done is high 2 cycles after the accepting edge.
REQ-019 MUL SHALL be iterative shift-add, one bit per cycle over WIDTH cycles: alu_done is high WIDTH+1 cycles after the accepting edge.
REQ-020 DIV/RMD SHALL be iterative restoring division, one quotient bit per cycle over WIDTH cycles: alu_done is high WIDTH+1 cycles after the accepting edge.
REQ-021 SUM/SUB SHALL return (A±B) mod 2^WIDTH; ovf = carry/borrow out when unsigned, or two's-complement overflow when signed.
REQ-022 MUL SHALL return the low WIDTH bits of the product; ovf=1 if the full 2*WIDTH product is not representable in WIDTH bits under the selected signedness.
REQ-023 Signed MUL/DIV/RMD SHALL operate on magnitudes and then fix the sign.
REQ-024 Signed DIV SHALL truncate toward zero; the RMD result SHALL take the sign of the dividend.
REQ-025 Divide by zero (B=0) SHALL set err=1; DIV returns all-ones, RMD returns A.
REQ-026 Signed DIV of MIN by -1 SHALL return MIN with ovf=1; RMD returns 0 with ovf=0.
REQ-027 An opcode not in REQ-009 SHALL set err=1 and calc_res=0; AND/OR/XOR SHALL set ovf=0 and err=0.
REQ-028 calc_res, ovf and err SHALL update only in the alu_done cycle and hold until the next alu_done.
REQ-029 start asserted in the same cycle alu_done is high SHALL be ignored; a new operation is accepted no earlier than the cycle after alu_done.

Reset
REQ-030 n_rst low SHALL immediately force IDLE, busy=0, alu_done=0, calc_res=0, ovf=0, err=0, and clear the counter and captured operands.
REQ-031 Reset mid-operation SHALL abort the operation; no alu_done is produced for it.

Verification (WIDTH=8)
REQ-032 SUM unsigned, 200+100 -> calc_res=44 (2Ch), ovf=1, alu_done 2 cycles after start.
REQ-033 MUL signed, -3 x 7 -> calc_res=EBh (-21), ovf=0, alu_done exactly 9 cycles after start; 16 x 16 signed -> ovf=1.
REQ-034 DIV/RMD signed, -7 / 2 -> Q=FDh (-3), R=FFh (-1); unsigned 200/7 -> Q=28, R=4, alu_done 9 cycles after start.
REQ-035 DIV by 0 -> err=1, calc_res=FFh, alu_done at 2 cycles; signed 80h/FFh -> calc_res=80h, ovf=1.
REQ-036 Second start pulsed mid-MUL, plus n_rst pulsed mid-DIV -> second start ignored; after reset all outputs are 0 and no alu_done is produced.
